pwm_generator: RTL and testbench
================================

// Module: pwm_generator
// PURPOSE
// - Fixed-period PWM source whose duty is stepped up/down by two push-button style inputs.
// - Each press (debounced, edge-detected) changes duty by one step (default 10% of period).
// - Sits between board buttons and an LED/motor driver; single clock domain.
// PARAMETERS
// - PERIOD        10  clocks per PWM period (>=2)
// - DUTY_INIT      5  duty (high clocks per period) after reset, 0..PERIOD
// - DUTY_STEP      1  duty change per accepted press
// - DEB_CYCLES     4  clocks a synchronized input must stay stable before accepted (>=1)
// PORTS
// - clk            in   1  rising-edge clock, single clock domain
// - rst_n          in   1  asynchronous, active-low reset
// - increase_duty  in   1  async button; one press = one duty step up
// - decrease_duty  in   1  async button; one press = one duty step down
// - PWM_OUT        out  1  registered PWM output
// BEHAVIOUR
// - Reset (rst_n=0, async): period counter=0, duty=DUTY_INIT, sync/debounce state=0, PWM_OUT=0.
// - Input path per button: 2-FF synchronizer -> debouncer -> rising-edge detector.
//   - Debouncer: stable level = synced level after it stays unchanged DEB_CYCLES consecutive clocks.
//   - Press = 0->1 transition of stable level; yields exactly one 1-clk pulse however long held.
//   - Release produces no action. Glitches shorter than DEB_CYCLES are ignored.
// - Latency (default parameters): button rise to duty register update = 2 (sync) + DEB_CYCLES + 1 clocks.
// - Duty arithmetic, unsigned, width clog2(PERIOD+1):
//   - inc pulse: duty = min(duty+DUTY_STEP, PERIOD), saturating; never wraps.
//   - dec pulse: duty = (duty<DUTY_STEP) ? 0 : duty-DUTY_STEP, saturating.
//   - inc and dec pulses in the same clock: no change.
// - Period counter: 0..PERIOD-1, increments every clock, wraps to 0.
// - PWM_OUT <= (cnt < duty_active).
//   - duty 0: constantly low. duty PERIOD: constantly high.
//   - Otherwise high for exactly duty clocks per period, beginning at cnt==0.
// - Reset mid-period: everything returns to reset values immediately.
//   - Debounce restarts: a held button must be released and pressed again to count.
// CONFIGURATION
// - Macro PWM_SHADOW_UPDATE_EN.
//   - Defined: duty_active loads from duty only when cnt wraps PERIOD-1 -> 0, so no partial or
//     glitched period ever appears; a change becomes visible at the next period start.
//   - Undefined: duty_active == duty; a change affects PWM_OUT on the clock after the update,
//     even mid-period.
// - Reset value of duty_active is DUTY_INIT in both builds.
// TESTING (clk 10 ns, default parameters)
// - Reset release, no presses -> PWM_OUT high 5 / low 5 clocks, repeating every 100 ns.
// - increase_duty held 100 ns, released 100 ns, repeated 3x -> duty 5->6->7->8.
//   - Final PWM_OUT is high 8 of 10 clocks; one step per press only.
// - Then 3 decrease_duty presses (100 ns each) -> duty 8->7->6->5; back to 50%.
// - 7 inc presses from 5 -> duty saturates at 10, PWM_OUT constantly 1.
//   - 12 dec presses -> duty saturates at 0, PWM_OUT constantly 0; no wrap.
// - 20 ns pulse on increase_duty -> ignored (duty unchanged).
//   - Both buttons pressed together -> duty unchanged.
// - rst_n pulled low mid-period while duty=8 -> PWM_OUT=0 at once; after release, duty=5.
// - With PWM_SHADOW_UPDATE_EN: a press accepted at cnt=3 -> waveform changes only from next cnt=0.

Source files
------------

// File: rtl/pwm_generator.sv
// Button-stepped PWM source: each button runs through sync -> debounce -> edge detect.
// Optional PWM_SHADOW_UPDATE_EN makes duty changes take effect only at period start.
module pwm_btn #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1, s2, stable, stable_q, armed;
  logic [CW-1:0] cnt;

  // armed stays low after reset until a debounced release is seen, so a button
  // held through reset never produces a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      armed    <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      stable_q <= stable;
      if (s2 != stable) begin
        if (cnt == LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (!armed && !s2) begin
        if (cnt == LAST) begin
          armed <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = stable & ~stable_q & armed;
endmodule

module pwm_generator #(
  parameter int PERIOD     = 10,
  parameter int DUTY_INIT  = 5,
  parameter int DUTY_STEP  = 1,
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic increase_duty,
  input  logic decrease_duty,
  output logic PWM_OUT
);
  localparam int CW = $clog2(PERIOD);
  localparam int DW = $clog2(PERIOD + 1);
  localparam logic [DW:0]   STEP_W = (DW+1)'(DUTY_STEP);
  localparam logic [DW:0]   PER_W  = (DW+1)'(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [1:0]    btn, pulse;
  logic [CW-1:0] cnt;
  logic [DW-1:0] duty, duty_nxt, duty_active;
  logic [DW:0]   up;

  assign btn = {decrease_duty, increase_duty};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    pwm_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn[g]),
      .pulse (pulse[g])
    );
  end

  assign up = {1'b0, duty} + STEP_W;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    duty_nxt = duty;
    if (pulse == 2'b01)
      duty_nxt = (up > PER_W) ? DW'(PERIOD) : up[DW-1:0];
    else if (pulse == 2'b10)
      duty_nxt = ({1'b0, duty} < STEP_W) ? '0 : duty - DW'(DUTY_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      duty    <= DW'(DUTY_INIT);
      PWM_OUT <= 1'b0;
    end else begin
      cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      duty    <= duty_nxt;
      PWM_OUT <= (DW'(cnt) < duty_active);
    end
  end

`ifdef PWM_SHADOW_UPDATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      duty_active <= DW'(DUTY_INIT);
    else if (cnt == CNT_LAST)
      duty_active <= duty;
  end
`else
  assign duty_active = duty;
`endif
endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: exact reset waveform, press latency, and a
// table of press vectors with hand-computed duty results.
module tb_pwm_generator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic increase_duty = 1'b0;
  logic decrease_duty = 1'b0;
  logic PWM_OUT;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic inc;
    logic dec;
    int   hold;
    int   exp_duty;
  } vec_t;

  vec_t tbl[40];
  int   n = 0;

  pwm_generator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .increase_duty (increase_duty),
    .decrease_duty (decrease_duty),
    .PWM_OUT       (PWM_OUT)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic inc, input logic dec, input int hold, input int exp_duty);
    tbl[n].inc = inc;
    tbl[n].dec = dec;
    tbl[n].hold = hold;
    tbl[n].exp_duty = exp_duty;
    n++;
  endtask

  // Hold reset a few clocks, check output is low, release just after an edge.
  task automatic do_reset(input logic clear_btn);
    rst_n = 1'b0;
    if (clear_btn) begin
      increase_duty = 1'b0;
      decrease_duty = 1'b0;
    end
    repeat (3) step();
    check("reset_out_low", int'(PWM_OUT), 0);
    rst_n = 1'b1;
  endtask

  // Ten consecutive samples: high count and circular rising-edge count.
  task automatic measure(output int highs, output int rises);
    logic s[10];
    highs = 0;
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      s[i] = PWM_OUT;
      if (PWM_OUT) highs++;
    end
    for (int i = 0; i < 10; i++)
      if (s[i] && !s[(i + 9) % 10]) rises++;
  endtask

  task automatic apply(input logic inc, input logic dec, input int hold, input int exp_duty,
                       input string tag);
    int h, r;
    increase_duty = inc;
    decrease_duty = dec;
    repeat (hold) step();
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    repeat (20) step();
    measure(h, r);
    check({tag, "_highs"}, h, exp_duty);
    check({tag, "_rises"}, r, (exp_duty == 0 || exp_duty == 10) ? 0 : 1);
  endtask

  // Exact 20-clock waveform right after reset release: 5 high, 5 low, twice.
  task automatic check_reset_pattern(input string tag);
    logic [9:0] p0, p1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k < 10) p0[9 - k] = PWM_OUT;
      else        p1[9 - (k - 10)] = PWM_OUT;
    end
    check({tag, "_period0"}, int'(p0), int'(10'b1111100000));
    check({tag, "_period1"}, int'(p1), int'(10'b1111100000));
  endtask

  initial begin
    logic [9:0] p0, p1, p2;
    int h, r, w;

    add(1, 0, 10, 6); add(1, 0, 10, 7); add(1, 0, 10, 8);
    add(0, 1, 10, 7); add(0, 1, 10, 6); add(0, 1, 10, 5);
    for (int i = 1; i <= 7; i++)  add(1, 0, 10, (5 + i > 10) ? 10 : 5 + i);
    for (int i = 1; i <= 12; i++) add(0, 1, 10, (10 - i < 0) ? 0 : 10 - i);
    add(1, 0, 2, 0);    // 20 ns glitch
    add(1, 0, 10, 1);
    add(1, 0, 3, 1);    // one clock short of the debounce window
    add(1, 0, 4, 2);    // exactly the debounce window
    add(0, 1, 3, 2);
    add(1, 1, 10, 2);   // both buttons cancel
    add(1, 0, 10, 3);

    // Reset state and exact default waveform.
    do_reset(1'b1);
    check_reset_pattern("init");

    // Press aligned to reset: first sampled at edge 7, duty updates at edge 13 (cnt=3).
    do_reset(1'b1);
    for (int k = 0; k < 30; k++) begin
      step();
      if (k < 10)      p0[9 - k] = PWM_OUT;
      else if (k < 20) p1[9 - (k - 10)] = PWM_OUT;
      else             p2[9 - (k - 20)] = PWM_OUT;
      if (k == 6)  increase_duty = 1'b1;
      if (k == 16) increase_duty = 1'b0;
    end
    check("latency_period0", int'(p0), int'(10'b1111100000));
`ifdef PWM_SHADOW_UPDATE_EN
    check("latency_period1", int'(p1), int'(10'b1111100000));
`else
    check("latency_period1", int'(p1), int'(10'b1111110000));
`endif
    check("latency_period2", int'(p2), int'(10'b1111110000));

    // Table of presses starting from duty 5.
    do_reset(1'b1);
    repeat (10) step();
    for (int i = 0; i < n; i++)
      apply(tbl[i].inc, tbl[i].dec, tbl[i].hold, tbl[i].exp_duty, $sformatf("vec%0d", i));

    // Raise duty to 8, then reset mid-period while output is high.
    for (int i = 4; i <= 8; i++) apply(1, 0, 10, i, $sformatf("to8_%0d", i));
    w = 0;
    while (PWM_OUT !== 1'b1 && w < 30) begin
      step();
      w++;
    end
    check("wait_high", int'(PWM_OUT), 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_low", int'(PWM_OUT), 0);
    step();
    step();
    rst_n = 1'b1;
    check_reset_pattern("midreset");

    // Button held through reset must not count; a fresh press does.
    increase_duty = 1'b1;
    do_reset(1'b0);
    repeat (30) step();
    increase_duty = 1'b0;
    repeat (20) step();
    measure(h, r);
    check("held_through_reset", h, 5);
    apply(1, 0, 10, 6, "after_held");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
